// File: rtl/vram_pkg.sv
// Shared defaults and the fill-engine state type for the double-buffered video RAM.
package vram_pkg;

    localparam int VRAM_PIX_W = 8;
    localparam int VRAM_DEPTH = 32768;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fillState_t;

endpackage

// File: rtl/vram_dp_bank.sv
// Plain dual-port RAM holding both frame banks: port A is read-only, port B is read/write
// with read-first behaviour. The array has no reset so it maps onto block RAM.
module vram_dp_bank #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
) (
    input  logic              i_clk,
    input  logic              i_aRe,
    input  logic [ADDR_W-1:0] i_aAddr,
    output logic [DATA_W-1:0] o_aData,
    input  logic              i_bRe,
    input  logic              i_bWe,
    input  logic [ADDR_W-1:0] i_bAddr,
    input  logic [DATA_W-1:0] i_bWdata,
    output logic [DATA_W-1:0] o_bData
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_aData;
    logic [DATA_W-1:0] r_bData;

    always_ff @(posedge i_clk) begin
        if (i_aRe) begin
            r_aData <= r_mem[i_aAddr];
        end
    end

    // The read samples the array before this edge's write lands, giving old data on a collision.
    always_ff @(posedge i_clk) begin
        if (i_bWe) begin
            r_mem[i_bAddr] <= i_bWdata;
        end
        if (i_bRe) begin
            r_bData <= r_mem[i_bAddr];
        end
    end

    assign o_aData = r_aData;
    assign o_bData = r_bData;

endmodule

// File: rtl/vram_dbuf.sv
// Double-buffered frame store: the display reads the front bank, the CPU and the fill engine
// own the back bank, and bank swaps are held off until vertical blanking with no fill running.
module vram_dbuf
    import vram_pkg::*;
#(
    parameter int PIX_W  = VRAM_PIX_W,
    parameter int DEPTH  = VRAM_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              MEM_CLK,
    input  logic              MEM_RST_N,
    input  logic              MEM_RDEN1,
    input  logic [ADDR_W-1:0] MEM_ADDR1,
    output logic [PIX_W-1:0]  MEM_DOUT1,
    output logic              MEM_VALID1,
    input  logic              MEM_RDEN2,
    input  logic              MEM_WE2,
    input  logic [ADDR_W-1:0] MEM_ADDR2,
    input  logic [PIX_W-1:0]  MEM_DIN2,
    output logic [PIX_W-1:0]  MEM_DOUT2,
    output logic              MEM_VALID2,
    input  logic              SWAP_REQ,
    input  logic              VBLANK,
    output logic              SWAP_PEND,
    output logic              FRONT_SEL,
    input  logic              FILL_START,
    input  logic [PIX_W-1:0]  FILL_VAL,
    output logic              FILL_BUSY,
    output logic              FILL_DONE
);

    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(DEPTH - 1);

    fillState_t        r_fillState;
    logic [ADDR_W-1:0] r_fillCnt;
    logic [PIX_W-1:0]  r_fillVal;
    logic              r_fillBusy;
    logic              r_fillDone;

    logic              r_frontSel;
    logic              r_swapPend;

    logic              r_valid1;
    logic              r_valid2;
    logic              r_zero1;
    logic              r_zero2;

    logic              w_inRange1;
    logic              w_inRange2;
    logic              w_p2Read;
    logic              w_p2Write;
    logic              w_swapNow;

    logic              w_aRe;
    logic [ADDR_W:0]   w_aAddr;
    logic              w_bRe;
    logic              w_bWe;
    logic [ADDR_W:0]   w_bAddr;
    logic [PIX_W-1:0]  w_bWdata;
    logic [PIX_W-1:0]  w_aData;
    logic [PIX_W-1:0]  w_bData;

    assign w_inRange1 = {1'b0, MEM_ADDR1} < DEPTH_X;
    assign w_inRange2 = {1'b0, MEM_ADDR2} < DEPTH_X;
    assign w_p2Read   = MEM_RDEN2 && !r_fillBusy;
    assign w_p2Write  = MEM_WE2 && !r_fillBusy && w_inRange2;
    assign w_swapNow  = r_swapPend && VBLANK && !r_fillBusy;

    assign w_aRe   = MEM_RDEN1 && w_inRange1;
    assign w_aAddr = {r_frontSel, MEM_ADDR1};

    // The fill engine takes the back-bank port outright; the CPU port is locked out meanwhile.
    always_comb begin
        w_bRe    = w_p2Read && w_inRange2;
        w_bWe    = w_p2Write;
        w_bAddr  = {~r_frontSel, MEM_ADDR2};
        w_bWdata = MEM_DIN2;
        if (r_fillBusy) begin
            w_bRe    = 1'b0;
            w_bWe    = 1'b1;
            w_bAddr  = {~r_frontSel, r_fillCnt};
            w_bWdata = r_fillVal;
        end
    end

    vram_dp_bank #(
        .DATA_W(PIX_W),
        .ADDR_W(ADDR_W + 1)
    ) u_bank (
        .i_clk   (MEM_CLK),
        .i_aRe   (w_aRe),
        .i_aAddr (w_aAddr),
        .o_aData (w_aData),
        .i_bRe   (w_bRe),
        .i_bWe   (w_bWe),
        .i_bAddr (w_bAddr),
        .i_bWdata(w_bWdata),
        .o_bData (w_bData)
    );

    always_ff @(posedge MEM_CLK or negedge MEM_RST_N) begin
        if (!MEM_RST_N) begin
            r_fillState <= ST_IDLE;
            r_fillCnt   <= '0;
            r_fillVal   <= '0;
            r_fillBusy  <= 1'b0;
            r_fillDone  <= 1'b0;
        end else begin
            case (r_fillState)
                ST_IDLE: begin
                    if (FILL_START) begin
                        r_fillState <= ST_FILL;
                        r_fillCnt   <= '0;
                        r_fillVal   <= FILL_VAL;
                        r_fillBusy  <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (r_fillCnt == LAST_PIX) begin
                        r_fillState <= ST_DONE;
                        r_fillBusy  <= 1'b0;
                        r_fillDone  <= 1'b1;
                    end else begin
                        r_fillCnt <= r_fillCnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_fillState <= ST_IDLE;
                    r_fillDone  <= 1'b0;
                end
                default: begin
                    r_fillState <= ST_IDLE;
                    r_fillBusy  <= 1'b0;
                    r_fillDone  <= 1'b0;
                end
            endcase
        end
    end

    // A request that lands on the swapping edge is swallowed by that swap.
    always_ff @(posedge MEM_CLK or negedge MEM_RST_N) begin
        if (!MEM_RST_N) begin
            r_frontSel <= 1'b0;
            r_swapPend <= 1'b0;
        end else if (w_swapNow) begin
            r_frontSel <= ~r_frontSel;
            r_swapPend <= 1'b0;
        end else if (SWAP_REQ) begin
            r_swapPend <= 1'b1;
        end
    end

    // r_zeroN masks the RAM output after reset and after an out-of-range read.
    always_ff @(posedge MEM_CLK or negedge MEM_RST_N) begin
        if (!MEM_RST_N) begin
            r_valid1 <= 1'b0;
            r_valid2 <= 1'b0;
            r_zero1  <= 1'b1;
            r_zero2  <= 1'b1;
        end else begin
            r_valid1 <= MEM_RDEN1;
            r_valid2 <= w_p2Read;
            if (MEM_RDEN1) begin
                r_zero1 <= !w_inRange1;
            end
            if (w_p2Read) begin
                r_zero2 <= !w_inRange2;
            end
        end
    end

    assign MEM_DOUT1  = r_zero1 ? '0 : w_aData;
    assign MEM_DOUT2  = r_zero2 ? '0 : w_bData;
    assign MEM_VALID1 = r_valid1;
    assign MEM_VALID2 = r_valid2;
    assign SWAP_PEND  = r_swapPend;
    assign FRONT_SEL  = r_frontSel;
    assign FILL_BUSY  = r_fillBusy;
    assign FILL_DONE  = r_fillDone;

endmodule

// File: doc/vram_dbuf.md
VRAM_DBUF -- requirements
Module: vram_dbuf

Interface
REQ-001 Parameter PIX_W, default 8, bits per pixel.
REQ-002 Parameter DEPTH, default 32768, pixels per bank (frame); each bank is DEPTH x PIX_W.
REQ-003 Parameter ADDR_W, default $clog2(DEPTH), pixel address width.
REQ-004 MEM_CLK  in  1  sole clock; all state changes on its rising edge.
REQ-005 MEM_RST_N  in  1  reset, asynchronous assert, active-low.
REQ-006 MEM_RDEN1  in  1  display-port read enable.
REQ-007 MEM_ADDR1  in  ADDR_W  display-port pixel address, front bank.
REQ-008 MEM_DOUT1  out  PIX_W  display-port read data.
REQ-009 MEM_VALID1  out  1  high one cycle after an accepted port-1 read.
REQ-010 MEM_RDEN2  in  1  CPU-port read enable.
REQ-011 MEM_WE2  in  1  CPU-port write enable.
REQ-012 MEM_ADDR2  in  ADDR_W  CPU-port pixel address, back bank.
REQ-013 MEM_DIN2  in  PIX_W  CPU-port write data.
REQ-014 MEM_DOUT2  out  PIX_W  CPU-port read data.
REQ-015 MEM_VALID2  out  1  high one cycle after an accepted port-2 read.
REQ-016 SWAP_REQ  in  1  single-cycle request to exchange front/back banks.
REQ-017 VBLANK  in  1  high during vertical blanking, synchronous to MEM_CLK.
REQ-018 SWAP_PEND  out  1  swap requested, not yet performed.
REQ-019 FRONT_SEL  out  1  index of bank currently displayed.
REQ-020 FILL_START  in  1  single-cycle request to fill back bank with FILL_VAL.
REQ-021 FILL_VAL  in  PIX_W  fill pixel value.
REQ-022 FILL_BUSY  out  1  fill engine active.
REQ-023 FILL_DONE  out  1  one-cycle pulse on fill completion.

Function
REQ-024 Storage SHALL be 2*DEPTH entries; physical address = {bank bit, pixel address}; port 1 SHALL use FRONT_SEL, port 2 SHALL use ~FRONT_SEL.
REQ-025 Reads SHALL have 1-cycle latency; MEM_DOUTn SHALL hold its last value when no read is accepted.
REQ-026 Port-2 read and write to the same address in one cycle SHALL return old data (read-first).
REQ-027 Bank selection for a read SHALL be the FRONT_SEL value in the cycle the read is sampled, even if a swap occurs that same edge.
REQ-028 Addresses >= DEPTH SHALL be ignored for writes and return 0 for reads (VALID still asserted).
REQ-029 SWAP_REQ SHALL set SWAP_PEND; a SWAP_REQ while SWAP_PEND is high SHALL have no further effect.
REQ-030 When SWAP_PEND=1, VBLANK=1 and FILL_BUSY=0, FRONT_SEL SHALL toggle and SWAP_PEND SHALL clear on that edge; SWAP_REQ arriving in that same cycle SHALL be absorbed.
REQ-031 Fill FSM states IDLE, FILL, DONE: IDLE->FILL on FILL_START (FILL_VAL latched, counter=0); FILL writes one pixel per cycle, counter 0..DEPTH-1; FILL->DONE after writing DEPTH-1; DONE->IDLE after one cycle.
REQ-032 FILL_BUSY SHALL be high exactly in FILL (DEPTH cycles); FILL_DONE SHALL be high exactly in DONE.
REQ-033 FILL_START outside IDLE SHALL be ignored.
REQ-034 During FILL, MEM_WE2 and MEM_RDEN2 SHALL be ignored (MEM_VALID2 low); port 1 SHALL be unaffected.
REQ-035 Swap pending during a fill SHALL be deferred until the first VBLANK cycle after FILL_BUSY falls.

Reset
REQ-036 MEM_RST_N low SHALL immediately force FRONT_SEL=0, SWAP_PEND=0, fill FSM=IDLE, FILL_BUSY=0, FILL_DONE=0, MEM_VALID1=0, MEM_VALID2=0, MEM_DOUT1=0, MEM_DOUT2=0.
REQ-037 Reset mid-fill SHALL abort the fill with no DONE pulse; memory contents SHALL NOT be reset.

Structure
REQ-038 Package vram_pkg SHALL hold the fill-state enum and default PIX_W/DEPTH constants.
REQ-039 Storage SHALL be sub-module vram_dp_bank: plain BRAM-inferable dual-port, one read port, one read/write port, no reset on the array.

Verification
REQ-040 Reset, port-2 write 0x5A at 0x0010, SWAP_REQ, VBLANK=1 -> FRONT_SEL=1 next edge; port-1 read 0x0010 -> 0x5A, VALID1 one cycle later.
REQ-041 SWAP_REQ with VBLANK=0 for 100 cycles -> SWAP_PEND=1, FRONT_SEL unchanged; VBLANK=1 -> swap on that edge, second SWAP_REQ while pending -> single toggle only.
REQ-042 DEPTH=16, FILL_START with FILL_VAL=0xFF -> FILL_BUSY 16 cycles, FILL_DONE 1 cycle, all 16 back-bank reads 0xFF, front bank unchanged.
REQ-043 SWAP_REQ+VBLANK=1 during fill -> no swap until FILL_BUSY falls; MEM_WE2 during fill -> no write.
REQ-044 Assert MEM_RST_N low at fill cycle 5 -> FILL_BUSY=0 immediately, no FILL_DONE, FRONT_SEL=0.
REQ-045 Port-2 write 0x33 then read+write 0x44 same address same cycle -> read returns 0x33, subsequent read 0x44.
